motion_corrector: RTL and testbench

- Per-point LiDAR deskew stage: removes ego-motion accumulated since scan start from each point.
- Computes c = p − v·dt on all three axes in Q16.16 fixed point.
- Flags points whose timestamp falls outside the scan window (dt < 0 or dt > T).
- Sits between the point-unpacking front end and the downstream point-cloud consumer. Fully pipelined, one point per cycle.

---
 rtl/mc_pkg.sv | 36 +++
 rtl/mc_axis.sv | 60 ++++++
 rtl/motion_corrector.sv | 104 ++++++++++
 tb/tb_motion_corrector.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants, types and the saturation helper for the motion corrector.
package mc_pkg;

    localparam int unsigned FRAC_BITS = 16;
    localparam int unsigned Q16_W     = 32;
    // 1.0 expressed in the Q0.30 x Q16.16 product domain used by the window compare.
    localparam logic [63:0] ONE_Q46   = 64'h0000_4000_0000_0000;

    // Widest datapath word the saturation helper supports; the +17 matches the
    // guard bits of the per-axis difference.
    localparam int unsigned MAX_WP    = 64;
    localparam int unsigned SAT_W     = MAX_WP + 17;

    typedef logic signed [Q16_W-1:0] q16_16_t;

    // Clamp a sign-extended value into the signed range of a wp-bit word.
    // The result is returned sign-extended; the caller keeps the low wp bits.
    function automatic logic signed [SAT_W-1:0] sat_to_wp(
        input logic signed [SAT_W-1:0] x,
        input int unsigned             wp
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = 1;
        hi  = (one <<< (wp - 1)) - one;
        lo  = ~hi;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/mc_axis.sv
// One axis of the deskew datapath: m = (v * dt) >>> 16, then c = sat(p - m).
module mc_axis
    import mc_pkg::*;
#(
    parameter int unsigned WP = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s1_en_i,
    input  logic                 s2_en_i,
    input  logic signed [WP-1:0] v_i,
    input  logic signed [WP-1:0] dt_eff_i,
    input  logic signed [WP-1:0] p_i,
    output logic signed [WP-1:0] c_o
);

    // |v * dt| >>> 16 stays below 2^(2*WP-17), so WP+17 bits hold m and p - m.
    localparam int unsigned DW = WP + 17;

    logic signed [2*WP-1:0] prod;
    logic signed [2*WP-1:0] prod_sh;
    logic signed [DW-1:0]   m_d;
    logic signed [DW-1:0]   m_q;
    logic signed [WP-1:0]   p_q;
    logic signed [DW-1:0]   diff;
    logic signed [WP-1:0]   c_d;
    logic signed [WP-1:0]   c_q;

    // Full-width signed product, floor shift, and saturated difference.
    always_comb begin
        prod    = (2*WP)'(v_i) * (2*WP)'(dt_eff_i);
        prod_sh = prod >>> FRAC_BITS;
        m_d     = prod_sh[DW-1:0];
        diff    = DW'(p_q) - m_q;
        c_d     = WP'(sat_to_wp(SAT_W'(diff), WP));
    end

    // Stage 1: capture motion term and raw coordinate for accepted points.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            p_q <= '0;
        end else if (s1_en_i) begin
            m_q <= m_d;
            p_q <= p_i;
        end
    end

    // Stage 2: corrected coordinate, held while no point is leaving stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
        end else if (s2_en_i) begin
            c_q <= c_d;
        end
    end

    assign c_o = c_q;

endmodule

// File: rtl/motion_corrector.sv
// Per-point LiDAR deskew: c = p - v * dt on three axes, with scan-window flag.
module motion_corrector
    import mc_pkg::*;
#(
    parameter int unsigned WP = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [WP-1:0] px,
    input  logic signed [WP-1:0] py,
    input  logic signed [WP-1:0] pz,
    input  logic signed [WP-1:0] dt,
    input  logic signed [WP-1:0] v_x,
    input  logic signed [WP-1:0] v_y,
    input  logic signed [WP-1:0] v_z,
    input  logic [31:0]          invT_q0_30,
    output logic                 out_valid,
    output logic signed [WP-1:0] cx,
    output logic signed [WP-1:0] cy,
    output logic signed [WP-1:0] cz,
    output logic                 dt_oor
);

    localparam int unsigned PW = WP + 32;

    logic signed [WP-1:0] dt_eff;
    logic [PW-1:0]        t_prod;
    logic                 oor_d;
    logic                 oor_q;
    logic                 valid_q;
    logic                 out_valid_q;
    logic                 dt_oor_q;

    // Negative dt is treated as zero motion; window check against dt * (1/T) > 1.0.
    always_comb begin
        dt_eff = dt[WP-1] ? '0 : dt;
        t_prod = PW'($unsigned(dt_eff)) * PW'(invT_q0_30);
        oor_d  = dt[WP-1] | (t_prod > PW'(ONE_Q46));
    end

    // Stage 1 valid and window flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                oor_q <= oor_d;
            end
        end
    end

    // Stage 2 valid and window flag; flag holds while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dt_oor_q    <= 1'b0;
        end else begin
            out_valid_q <= valid_q;
            if (valid_q) begin
                dt_oor_q <= oor_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dt_oor    = dt_oor_q;

    mc_axis #(.WP(WP)) u_axis_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1_en_i (in_valid),
        .s2_en_i (valid_q),
        .v_i     (v_x),
        .dt_eff_i(dt_eff),
        .p_i     (px),
        .c_o     (cx)
    );

    mc_axis #(.WP(WP)) u_axis_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1_en_i (in_valid),
        .s2_en_i (valid_q),
        .v_i     (v_y),
        .dt_eff_i(dt_eff),
        .p_i     (py),
        .c_o     (cy)
    );

    mc_axis #(.WP(WP)) u_axis_z (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1_en_i (in_valid),
        .s2_en_i (valid_q),
        .v_i     (v_z),
        .dt_eff_i(dt_eff),
        .p_i     (pz),
        .c_o     (cz)
    );

endmodule

// File: tb/tb_motion_corrector.sv
// Self-checking bench for motion_corrector against an arithmetic reference model.
module tb_motion_corrector;

    localparam int unsigned WP = 32;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic signed [WP-1:0] px, py, pz, dt, v_x, v_y, v_z;
    logic [31:0]          invT_q0_30;
    logic                 out_valid;
    logic signed [WP-1:0] cx, cy, cz;
    logic                 dt_oor;

    int total;
    int bad;

    motion_corrector #(.WP(WP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .px        (px),
        .py        (py),
        .pz        (pz),
        .dt        (dt),
        .v_x       (v_x),
        .v_y       (v_y),
        .v_z       (v_z),
        .invT_q0_30(invT_q0_30),
        .out_valid (out_valid),
        .cx        (cx),
        .cy        (cy),
        .cz        (cz),
        .dt_oor    (dt_oor)
    );

    always #5 clk = ~clk;

    // Reference: c = clamp(p - floor(v * max(dt,0) / 2^16)) into int32.
    function automatic logic [31:0] ref_c(input longint p, input longint v, input longint t);
        longint te;
        longint prod;
        longint m;
        longint c;
        logic [63:0] cv;
        te   = (t < 0) ? 64'sd0 : t;
        prod = v * te;
        m    = prod / 65536;
        if (prod < 0 && (prod % 65536) != 0) m = m - 1;
        c = p - m;
        if (c > 64'sd2147483647) c = 64'sd2147483647;
        if (c < -64'sd2147483648) c = -64'sd2147483648;
        cv = c;
        return cv[31:0];
    endfunction

    // Reference: outside window when dt < 0 or dt / T > 1.0.
    function automatic logic ref_oor(input longint t, input longint invt);
        if (t < 0) return 1'b1;
        return (t * invt) > (64'sd1 <<< 46);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (dt_oor !== 1'b0) begin bad++; $display("FAIL reset_oor got %b want 0", dt_oor); end
        if (cx !== 32'd0) begin bad++; $display("FAIL reset_cx got %h want 0", cx); end
        if (cy !== 32'd0) begin bad++; $display("FAIL reset_cy got %h want 0", cy); end
        if (cz !== 32'd0) begin bad++; $display("FAIL reset_cz got %h want 0", cz); end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got %b want 0", out_valid); end
    endtask

    task automatic test_directed();
        logic signed [31:0] t_vx [7] = '{32'sd196608, 32'sd196608, 32'sd196608, 32'sd196608,
                                          -32'sd6553600, 32'sd6553600, 32'sd0};
        logic signed [31:0] t_px [7] = '{32'sd655360, 32'sd655360, 32'sd655360, 32'sd65536,
                                          32'sh7FFF0000, 32'sh80010000, 32'sd12345};
        logic signed [31:0] t_py [7] = '{32'sd0, 32'sd0, 32'sd0, 32'sd131072,
                                          32'sd0, 32'sd0, -32'sd777};
        logic signed [31:0] t_pz [7] = '{32'sd0, 32'sd0, 32'sd0, 32'sd196608,
                                          32'sd0, 32'sd0, 32'sh7FFFFFFF};
        logic signed [31:0] t_dt [7] = '{32'sd6553, 32'sd32768, 32'sd39321, -32'sd6553,
                                          32'sd65536, 32'sd65536, 32'sd20000};
        logic [31:0]        t_cx [7] = '{32'd635701, 32'd557056, 32'd537397, 32'd65536,
                                          32'h7FFFFFFF, 32'h80000000, 32'd12345};
        logic               t_oor [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            v_x = t_vx[i]; v_y = 0; v_z = 0;
            px = t_px[i]; py = t_py[i]; pz = t_pz[i];
            dt = t_dt[i];
            invT_q0_30 = 32'h8000_0000;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            px = $urandom; py = $urandom; pz = $urandom; dt = $urandom;
            @(negedge clk);
            total += 5;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_valid got %b want 1", i, out_valid); end
            if (cx !== t_cx[i]) begin bad++; $display("FAIL dir%0d_cx got %h want %h", i, cx, t_cx[i]); end
            if (cy !== t_py[i]) begin bad++; $display("FAIL dir%0d_cy got %h want %h", i, cy, t_py[i]); end
            if (cz !== t_pz[i]) begin bad++; $display("FAIL dir%0d_cz got %h want %h", i, cz, t_pz[i]); end
            if (dt_oor !== t_oor[i]) begin bad++; $display("FAIL dir%0d_oor got %b want %b", i, dt_oor, t_oor[i]); end
            @(negedge clk);
            total += 3;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_drop got %b want 0", i, out_valid); end
            if (cx !== t_cx[i]) begin bad++; $display("FAIL dir%0d_hold_cx got %h want %h", i, cx, t_cx[i]); end
            if (dt_oor !== t_oor[i]) begin bad++; $display("FAIL dir%0d_hold_oor got %b want %b", i, dt_oor, t_oor[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] bx [8], by [8], bz [8], bdt [8];
        logic signed [31:0] vx, vy, vz;
        int high;
        high = 0;
        vx = $signed($urandom_range(0, 1310720)) - 32'sd655360;
        vy = $signed($urandom_range(0, 1310720)) - 32'sd655360;
        vz = $signed($urandom_range(0, 1310720)) - 32'sd655360;
        for (int i = 0; i < 8; i++) begin
            bx[i] = $urandom; by[i] = $urandom; bz[i] = $urandom;
            bdt[i] = 32'(i * 3277);
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) high++;
            total++;
            if (cyc >= 2 && cyc < 10) begin
                if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d_valid got %b want 1", cyc, out_valid); end
                total += 4;
                if (cx !== ref_c(bx[cyc-2], vx, bdt[cyc-2])) begin bad++;
                    $display("FAIL b2b%0d_cx got %h want %h", cyc, cx, ref_c(bx[cyc-2], vx, bdt[cyc-2])); end
                if (cy !== ref_c(by[cyc-2], vy, bdt[cyc-2])) begin bad++;
                    $display("FAIL b2b%0d_cy got %h want %h", cyc, cy, ref_c(by[cyc-2], vy, bdt[cyc-2])); end
                if (cz !== ref_c(bz[cyc-2], vz, bdt[cyc-2])) begin bad++;
                    $display("FAIL b2b%0d_cz got %h want %h", cyc, cz, ref_c(bz[cyc-2], vz, bdt[cyc-2])); end
                if (dt_oor !== 1'b0) begin bad++; $display("FAIL b2b%0d_oor got %b want 0", cyc, dt_oor); end
            end else begin
                if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b%0d_idle got %b want 0", cyc, out_valid); end
            end
            if (cyc < 8) begin
                v_x = vx; v_y = vy; v_z = vz;
                px = bx[cyc]; py = by[cyc]; pz = bz[cyc]; dt = bdt[cyc];
                invT_q0_30 = 32'h8000_0000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        total++;
        if (high != 8) begin bad++; $display("FAIL b2b_count got %0d want 8", high); end
    endtask

    task automatic test_random();
        localparam int N = 300;
        logic               rv [N];
        logic signed [31:0] rx [N], ry [N], rz [N], rdt [N], rvx [N], rvy [N], rvz [N];
        logic [31:0]        rinv [N];
        logic [31:0]        last_x, last_y, last_z, inv_cur, ex, ey, ez;
        logic               last_o, have_last, eo;
        int                 mode;
        have_last = 1'b0;
        last_x = 0; last_y = 0; last_z = 0; last_o = 0;
        inv_cur = 32'h8000_0000;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                if (rv[i-2]) begin
                    ex = ref_c(rx[i-2], rvx[i-2], rdt[i-2]);
                    ey = ref_c(ry[i-2], rvy[i-2], rdt[i-2]);
                    ez = ref_c(rz[i-2], rvz[i-2], rdt[i-2]);
                    eo = ref_oor(rdt[i-2], {32'd0, rinv[i-2]});
                    total += 5;
                    if (out_valid !== 1'b1) begin bad++; $display("FAIL rnd%0d_valid got %b want 1", i, out_valid); end
                    if (cx !== ex) begin bad++; $display("FAIL rnd%0d_cx got %h want %h", i, cx, ex); end
                    if (cy !== ey) begin bad++; $display("FAIL rnd%0d_cy got %h want %h", i, cy, ey); end
                    if (cz !== ez) begin bad++; $display("FAIL rnd%0d_cz got %h want %h", i, cz, ez); end
                    if (dt_oor !== eo) begin bad++; $display("FAIL rnd%0d_oor got %b want %b", i, dt_oor, eo); end
                    last_x = ex; last_y = ey; last_z = ez; last_o = eo;
                    have_last = 1'b1;
                end else begin
                    total++;
                    if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd%0d_idle got %b want 0", i, out_valid); end
                    if (have_last) begin
                        total += 2;
                        if (cx !== last_x) begin bad++; $display("FAIL rnd%0d_hold_cx got %h want %h", i, cx, last_x); end
                        if (dt_oor !== last_o) begin bad++; $display("FAIL rnd%0d_hold_oor got %b want %b", i, dt_oor, last_o); end
                    end
                end
            end
            if (i < N) begin
                if (i % 40 == 0) begin
                    case ($urandom_range(0, 2))
                        0: inv_cur = 32'h8000_0000;
                        1: inv_cur = 32'h4000_0000;
                        default: inv_cur = 32'hFFFF_FFFF;
                    endcase
                end
                mode = $urandom_range(0, 9);
                rv[i]   = ($urandom_range(0, 9) < 7);
                rx[i]   = $urandom; ry[i] = $urandom; rz[i] = $urandom;
                if (mode == 0) begin
                    rvx[i] = 0; rvy[i] = 0; rvz[i] = 0;
                end else if (mode < 3) begin
                    rvx[i] = $urandom; rvy[i] = $urandom; rvz[i] = $urandom;
                end else begin
                    rvx[i] = $signed($urandom_range(0, 2621440)) - 32'sd1310720;
                    rvy[i] = $signed($urandom_range(0, 2621440)) - 32'sd1310720;
                    rvz[i] = $signed($urandom_range(0, 2621440)) - 32'sd1310720;
                end
                if (mode == 1) rdt[i] = $urandom;
                else if (mode == 2) rdt[i] = (inv_cur == 32'h4000_0000) ? 32'sd65536 :
                                             (inv_cur == 32'h8000_0000) ? 32'sd32768 : 32'sd16384;
                else rdt[i] = $signed($urandom_range(0, 91750)) - 32'sd13107;
                rinv[i] = inv_cur;
                in_valid = rv[i];
                px = rx[i]; py = ry[i]; pz = rz[i]; dt = rdt[i];
                v_x = rvx[i]; v_y = rvy[i]; v_z = rvz[i];
                invT_q0_30 = rinv[i];
            end else begin
                in_valid = 1'b0;
                v_x = $urandom; invT_q0_30 = $urandom;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic signed [31:0] mx [4], mdt [4];
        logic [31:0] e;
        v_x = 32'sd131072; v_y = 0; v_z = 0; py = 0; pz = 0;
        invT_q0_30 = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            mx[i] = $urandom;
            mdt[i] = $signed($urandom_range(0, 32768));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = ref_c(mx[i-2], 131072, mdt[i-2]);
                total += 2;
                if (out_valid !== 1'b1) begin bad++; $display("FAIL mid%0d_valid got %b want 1", i, out_valid); end
                if (cx !== e) begin bad++; $display("FAIL mid%0d_cx got %h want %h", i, cx, e); end
            end
            px = mx[i]; dt = mdt[i];
            in_valid = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        if (cx !== 32'd0) begin bad++; $display("FAIL mid_rst_cx got %h want 0", cx); end
        if (cy !== 32'd0) begin bad++; $display("FAIL mid_rst_cy got %h want 0", cy); end
        if (cz !== 32'd0) begin bad++; $display("FAIL mid_rst_cz got %h want 0", cz); end
        if (dt_oor !== 1'b0) begin bad++; $display("FAIL mid_rst_oor got %b want 0", dt_oor); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total += 2;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale%0d_valid got %b want 0", i, out_valid); end
            if (cx !== 32'd0) begin bad++; $display("FAIL mid_stale%0d_cx got %h want 0", i, cx); end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        px = 0; py = 0; pz = 0; dt = 0;
        v_x = 0; v_y = 0; v_z = 0;
        invT_q0_30 = 32'h8000_0000;
        total = 0;
        bad = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
